// File: rtl/i2c_target_rx_fifo_if.sv
// ----------------------------------------------------------------------------
// i2c_target_rx_fifo_if
// Valid/ready byte stream from the I2C target receiver to a local consumer.
//   rd_data   8  FIFO head byte, meaningful while rd_valid=1
//   rd_valid  1  FIFO not empty
//   rd_ready  1  consumer pop request; pop when rd_valid & rd_ready
// master: producer (receiver), slave: consumer.
// ----------------------------------------------------------------------------
interface i2c_target_rx_fifo_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    modport master (
        output rd_data,
        output rd_valid,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        output rd_ready
    );
endinterface

// File: rtl/i2c_target_rx_fifo.sv
// ----------------------------------------------------------------------------
// i2c_target_rx_fifo
// I2C target-side write receiver. Synchronises SCL/SDA, decodes START/STOP,
// matches a 7-bit address (write only), shifts data bytes MSB first, ACKs
// each accepted byte and buffers it in a first-word-fall-through FIFO.
// NACKs (releases SDA) on address mismatch, read request or full FIFO.
// Ports:
//   clk          system clock (>= 8x SCL)
//   rstn         synchronous active-low reset
//   scl_i/sda_i  asynchronous pad inputs
//   sda_oe       1 = pull SDA low (ACK)
//   rd_if        valid/ready consumer stream (master side)
//   fifo_level   current FIFO entry count (0..FIFO_DEPTH)
//   frame_start  1-clk pulse on START / repeated START
//   frame_stop   1-clk pulse on STOP
//   overflow     1-clk pulse when a byte is NACKed because the FIFO is full
// ----------------------------------------------------------------------------
module i2c_target_rx_fifo #(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          scl_i,
    input  logic                          sda_i,
    output logic                          sda_oe,
    i2c_target_rx_fifo_if.master          rd_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_start,
    output logic                          frame_stop,
    output logic                          overflow
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StData,
        StDataAck,
        StIgnore
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronisers; reset to the idle-bus level so reset release
    // never looks like a START.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // SCL must be high on both samples so an SDA move at an SCL edge is not a condition.
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q, shift_nxt;
    logic       ack_on_q;
    logic       sda_oe_q, frame_start_q, frame_stop_q, overflow_q;

    logic [LvlW-1:0] level_q;
    logic            fifo_full, push, pop, last_bit;

    // Byte as it will look once the current SDA sample lands.
    always_comb begin
        shift_nxt            = shift_q;
        shift_nxt[bit_cnt_q] = sda_s;
    end

    assign fifo_full = (level_q == LvlW'(FIFO_DEPTH));
    assign last_bit  = scl_rise & (bit_cnt_q == 3'd0);
    assign push      = (state_q == StData) & last_bit & ~fifo_full & ~start_det & ~stop_det;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= StIdle;
            bit_cnt_q     <= 3'd7;
            shift_q       <= 8'h00;
            ack_on_q      <= 1'b0;
            sda_oe_q      <= 1'b0;
            frame_start_q <= 1'b0;
            frame_stop_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            frame_stop_q  <= 1'b0;
            overflow_q    <= 1'b0;
            if (stop_det) begin
                state_q      <= StIdle;
                bit_cnt_q    <= 3'd7;
                shift_q      <= 8'h00;
                ack_on_q     <= 1'b0;
                sda_oe_q     <= 1'b0;
                frame_stop_q <= 1'b1;
            end else if (start_det) begin
                state_q       <= StAddr;
                bit_cnt_q     <= 3'd7;
                shift_q       <= 8'h00;
                ack_on_q      <= 1'b0;
                sda_oe_q      <= 1'b0;
                frame_start_q <= 1'b1;
            end else begin
                case (state_q)
                    StAddr: begin
                        if (scl_rise) begin
                            shift_q <= shift_nxt;
                            if (bit_cnt_q == 3'd0) begin
                                bit_cnt_q <= 3'd7;
                                if (shift_nxt[7:1] == DEV_ADDR && !shift_nxt[0]) begin
                                    state_q <= StAddrAck;
                                end else begin
                                    state_q <= StIgnore;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q - 3'd1;
                            end
                        end
                    end
                    StData: begin
                        if (scl_rise) begin
                            shift_q <= shift_nxt;
                            if (bit_cnt_q == 3'd0) begin
                                bit_cnt_q <= 3'd7;
                                if (!fifo_full) begin
                                    state_q <= StDataAck;
                                end else begin
                                    overflow_q <= 1'b1;
                                    state_q    <= StIgnore;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q - 3'd1;
                            end
                        end
                    end
                    // First SCL fall opens the ACK slot, the second one closes it.
                    StAddrAck, StDataAck: begin
                        if (scl_fall) begin
                            if (!ack_on_q) begin
                                ack_on_q <= 1'b1;
                                sda_oe_q <= 1'b1;
                            end else begin
                                ack_on_q  <= 1'b0;
                                sda_oe_q  <= 1'b0;
                                state_q   <= StData;
                                bit_cnt_q <= 3'd7;
                                shift_q   <= 8'h00;
                            end
                        end
                    end
                    StIdle, StIgnore: begin
                        sda_oe_q <= 1'b0;
                    end
                    default: begin
                        state_q  <= StIdle;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;

    assign pop = rd_if.rd_valid & rd_if.rd_ready;

    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem_q[wr_ptr_q] <= shift_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LvlW'(1);
                2'b01:   level_q <= level_q - LvlW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign rd_if.rd_valid = (level_q != '0);
    assign rd_if.rd_data  = rd_if.rd_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_level     = level_q;
    assign sda_oe         = sda_oe_q;
    assign frame_start    = frame_start_q;
    assign frame_stop     = frame_stop_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_i2c_target_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_i2c_target_rx_fifo
// Directed bench: bit-bangs an I2C host against the receiver (FIFO_DEPTH=4),
// models the open-drain SDA wire, and checks ACK slots, FIFO contents,
// levels and status pulses against hand-computed values.
// ----------------------------------------------------------------------------
module tb_i2c_target_rx_fifo;

    localparam int unsigned Depth = 4;
    localparam int unsigned LvlW  = $clog2(Depth) + 1;

    logic            clk = 1'b0;
    logic            rstn;
    logic            scl_host, sda_host;
    logic            sda_line;
    logic            sda_oe, frame_start, frame_stop, overflow;
    logic [LvlW-1:0] fifo_level;

    always #5 clk = ~clk;

    // Open-drain wire: host releases to 1, either side may pull low.
    assign sda_line = sda_host & ~sda_oe;

    i2c_target_rx_fifo_if u_rd_if ();

    i2c_target_rx_fifo #(
        .DEV_ADDR    (7'h50),
        .FIFO_DEPTH  (Depth),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .scl_i       (scl_host),
        .sda_i       (sda_line),
        .sda_oe      (sda_oe),
        .rd_if       (u_rd_if),
        .fifo_level  (fifo_level),
        .frame_start (frame_start),
        .frame_stop  (frame_stop),
        .overflow    (overflow)
    );

    // Event monitors; tests compare deltas of these running counts.
    int   oe_rises = 0, fs_cycles = 0, fp_cycles = 0, ovf_cycles = 0;
    logic oe_prev  = 1'b0;

    always @(posedge clk) begin
        oe_prev <= sda_oe;
        if (sda_oe && !oe_prev) oe_rises   <= oe_rises + 1;
        if (frame_start)        fs_cycles  <= fs_cycles + 1;
        if (frame_stop)         fp_cycles  <= fp_cycles + 1;
        if (overflow)           ovf_cycles <= ovf_cycles + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_host = 1'b1;
        tick(4);
        scl_host = 1'b1;
        tick(8);
        sda_host = 1'b0;
        tick(8);
        scl_host = 1'b0;
        tick(4);
    endtask

    task automatic i2c_stop();
        sda_host = 1'b0;
        tick(4);
        scl_host = 1'b1;
        tick(8);
        sda_host = 1'b1;
        tick(8);
    endtask

    task automatic send_bit(input logic b);
        sda_host = b;
        tick(4);
        scl_host = 1'b1;
        tick(8);
        scl_host = 1'b0;
        tick(4);
    endtask

    // Eight data bits then the ninth clock with SDA released; ack = target pulled low.
    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_host = 1'b1;
        tick(4);
        scl_host = 1'b1;
        tick(4);
        ack = sda_oe;
        tick(4);
        scl_host = 1'b0;
        tick(4);
    endtask

    task automatic pop_one();
        u_rd_if.rd_ready = 1'b1;
        tick(1);
        u_rd_if.rd_ready = 1'b0;
    endtask

    logic       ack;
    int         oe0, fs0, fp0, ov0;
    logic [7:0] bytes4 [5];

    initial begin
        bytes4 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        rstn             = 1'b0;
        scl_host         = 1'b1;
        sda_host         = 1'b1;
        u_rd_if.rd_ready = 1'b0;
        tick(3);
        check_eq("rst_sda_oe", sda_oe, 0);
        check_eq("rst_rd_valid", u_rd_if.rd_valid, 0);
        check_eq("rst_rd_data", u_rd_if.rd_data, 8'h00);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_pulses", {frame_start, frame_stop, overflow}, 0);
        rstn = 1'b1;
        tick(4);

        // Pop on empty FIFO must be ignored.
        pop_one();
        check_eq("empty_pop_level", fifo_level, 0);

        // 1: basic write of two bytes.
        oe0 = oe_rises; fs0 = fs_cycles; fp0 = fp_cycles;
        i2c_start();
        send_byte(8'hA0, ack); check_eq("t1_addr_ack", ack, 1);
        send_byte(8'hA5, ack); check_eq("t1_d0_ack", ack, 1);
        send_byte(8'h3C, ack); check_eq("t1_d1_ack", ack, 1);
        i2c_stop();
        check_eq("t1_ack_slots", oe_rises - oe0, 3);
        check_eq("t1_frame_start", fs_cycles - fs0, 1);
        check_eq("t1_frame_stop", fp_cycles - fp0, 1);
        check_eq("t1_level", fifo_level, 2);
        check_eq("t1_valid", u_rd_if.rd_valid, 1);
        check_eq("t1_head0", u_rd_if.rd_data, 8'hA5);
        pop_one();
        check_eq("t1_head1", u_rd_if.rd_data, 8'h3C);
        check_eq("t1_level1", fifo_level, 1);
        pop_one();
        check_eq("t1_level0", fifo_level, 0);
        check_eq("t1_valid0", u_rd_if.rd_valid, 0);

        // 2: address mismatch.
        oe0 = oe_rises;
        i2c_start();
        send_byte(8'hA2, ack); check_eq("t2_addr_nack", ack, 0);
        send_byte(8'h11, ack); check_eq("t2_data_nack", ack, 0);
        i2c_stop();
        check_eq("t2_no_oe", oe_rises - oe0, 0);
        check_eq("t2_level", fifo_level, 0);

        // 3: read request is NACKed.
        oe0 = oe_rises;
        i2c_start();
        send_byte(8'hA1, ack); check_eq("t3_addr_nack", ack, 0);
        send_byte(8'h22, ack); check_eq("t3_data_nack", ack, 0);
        i2c_stop();
        check_eq("t3_no_oe", oe_rises - oe0, 0);
        check_eq("t3_level", fifo_level, 0);

        // 4: overflow with no consumer.
        ov0 = ovf_cycles;
        i2c_start();
        send_byte(8'hA0, ack); check_eq("t4_addr_ack", ack, 1);
        for (int i = 0; i < 5; i++) begin
            send_byte(bytes4[i], ack);
            check_eq($sformatf("t4_ack%0d", i), ack, (i < 4) ? 1 : 0);
        end
        i2c_stop();
        check_eq("t4_overflow", ovf_cycles - ov0, 1);
        check_eq("t4_level", fifo_level, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t4_head%0d", i), u_rd_if.rd_data, bytes4[i]);
            pop_one();
        end
        check_eq("t4_drained", fifo_level, 0);

        // 5: repeated START drops a partial byte.
        oe0 = oe_rises; fs0 = fs_cycles;
        i2c_start();
        send_byte(8'hA0, ack); check_eq("t5_addr_ack", ack, 1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        i2c_start();
        send_byte(8'hA0, ack); check_eq("t5_addr2_ack", ack, 1);
        send_byte(8'h77, ack); check_eq("t5_data_ack", ack, 1);
        i2c_stop();
        check_eq("t5_frame_start", fs_cycles - fs0, 2);
        check_eq("t5_ack_slots", oe_rises - oe0, 3);
        check_eq("t5_level", fifo_level, 1);
        check_eq("t5_head", u_rd_if.rd_data, 8'h77);
        pop_one();

        // 6: reset inside the third data ACK slot.
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h10, ack);
        send_byte(8'h20, ack);
        for (int i = 7; i >= 0; i--) send_bit(8'h30 >> i);
        sda_host = 1'b1;
        tick(4);
        scl_host = 1'b1;
        tick(2);
        check_eq("t6_oe_in_slot", sda_oe, 1);
        check_eq("t6_level3", fifo_level, 3);
        rstn = 1'b0;
        tick(1);
        check_eq("t6_rst_oe", sda_oe, 0);
        check_eq("t6_rst_level", fifo_level, 0);
        check_eq("t6_rst_valid", u_rd_if.rd_valid, 0);
        rstn = 1'b1;
        tick(2);
        scl_host = 1'b0;
        tick(8);
        i2c_start();
        send_byte(8'hA0, ack); check_eq("t6_addr_ack", ack, 1);
        send_byte(8'h5A, ack); check_eq("t6_data_ack", ack, 1);
        i2c_stop();
        check_eq("t6_level", fifo_level, 1);
        check_eq("t6_head", u_rd_if.rd_data, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
